// File: rtl/tour_cmd_seq_if.sv
// Command-processor handshake bundle for tour_cmd_seq.
// The sequencer is the master: it drives cmd/cmd_rdy/resp and the processor acknowledges.
interface tour_cmd_seq_if;
    logic [15:0] cmd;
    logic        cmd_rdy;
    logic        clr_cmd_rdy;
    logic        send_resp;
    logic [7:0]  resp;

    modport master (
        output cmd, cmd_rdy, resp,
        input  clr_cmd_rdy, send_resp
    );

    modport slave (
        input  cmd, cmd_rdy, resp,
        output clr_cmd_rdy, send_resp
    );
endinterface

// File: rtl/tour_cmd_seq.sv
// Knight's-tour playback sequencer and UART/tour command mux.
// Optional macro TOUR_FANFARE_EN: the horizontal leg uses the move-with-fanfare opcode.
module tour_cmd_seq (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start_tour,
    input  logic [7:0]            move,
    output logic [4:0]            indx,
    input  logic [15:0]           cmd_UART,
    input  logic                  cmd_rdy_UART,
    output logic                  clr_cmd_rdy_UART,
    output logic                  tour_done,
    tour_cmd_seq_if.master        proc
);

    localparam logic [3:0] MOVE_OP = 4'b0100;
`ifdef TOUR_FANFARE_EN
    localparam logic [3:0] HORZ_OP = 4'b0101;
`else
    localparam logic [3:0] HORZ_OP = 4'b0100;
`endif

    localparam logic [7:0] HEAD_N    = 8'h00;
    localparam logic [7:0] HEAD_S    = 8'h7F;
    localparam logic [7:0] HEAD_E    = 8'hBF;
    localparam logic [7:0] HEAD_W    = 8'h3F;
    localparam logic [7:0] RESP_LEG  = 8'h5A;
    localparam logic [7:0] RESP_ACK  = 8'hA5;
    localparam logic [4:0] LAST_INDX = 5'd23;

    typedef enum logic [2:0] {IDLE, VERT, WAIT_V, HORZ, WAIT_H} state_t;

    state_t     state, state_nxt;
    logic [4:0] indx_nxt;
    logic       done_nxt;

    logic [2:0] sel;
    logic [7:0] v_head, h_head;
    logic [3:0] v_sq, h_sq;

    // Lowest set bit wins; an all-zero move falls through to bit0.
    always_comb begin
        casez (move)
            8'b???????1: sel = 3'd0;
            8'b??????10: sel = 3'd1;
            8'b?????100: sel = 3'd2;
            8'b????1000: sel = 3'd3;
            8'b???10000: sel = 3'd4;
            8'b??100000: sel = 3'd5;
            8'b?1000000: sel = 3'd6;
            8'b10000000: sel = 3'd7;
            default:     sel = 3'd0;
        endcase
    end

    always_comb begin
        v_head = HEAD_N;
        v_sq   = 4'd2;
        h_head = HEAD_W;
        h_sq   = 4'd1;
        case (sel)
            3'd0: begin v_head = HEAD_N; v_sq = 4'd2; h_head = HEAD_W; h_sq = 4'd1; end
            3'd1: begin v_head = HEAD_N; v_sq = 4'd2; h_head = HEAD_E; h_sq = 4'd1; end
            3'd2: begin v_head = HEAD_N; v_sq = 4'd1; h_head = HEAD_W; h_sq = 4'd2; end
            3'd3: begin v_head = HEAD_S; v_sq = 4'd1; h_head = HEAD_W; h_sq = 4'd2; end
            3'd4: begin v_head = HEAD_S; v_sq = 4'd2; h_head = HEAD_W; h_sq = 4'd1; end
            3'd5: begin v_head = HEAD_S; v_sq = 4'd2; h_head = HEAD_E; h_sq = 4'd1; end
            3'd6: begin v_head = HEAD_S; v_sq = 4'd1; h_head = HEAD_E; h_sq = 4'd2; end
            3'd7: begin v_head = HEAD_N; v_sq = 4'd1; h_head = HEAD_E; h_sq = 4'd2; end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            indx      <= '0;
            tour_done <= 1'b0;
        end else begin
            state     <= state_nxt;
            indx      <= indx_nxt;
            tour_done <= done_nxt;
        end
    end

    always_comb begin
        state_nxt        = state;
        indx_nxt         = indx;
        done_nxt         = 1'b0;
        proc.cmd         = {MOVE_OP, v_head, v_sq};
        proc.cmd_rdy     = 1'b0;
        proc.resp        = RESP_LEG;
        clr_cmd_rdy_UART = 1'b0;

        case (state)
            IDLE: begin
                proc.cmd         = cmd_UART;
                proc.cmd_rdy     = cmd_rdy_UART;
                proc.resp        = RESP_ACK;
                clr_cmd_rdy_UART = proc.clr_cmd_rdy;
                if (start_tour) begin
                    indx_nxt  = '0;
                    state_nxt = VERT;
                end
            end
            VERT: begin
                proc.cmd_rdy = 1'b1;
                if (proc.clr_cmd_rdy) state_nxt = WAIT_V;
            end
            WAIT_V: begin
                if (proc.send_resp) state_nxt = HORZ;
            end
            HORZ: begin
                proc.cmd     = {HORZ_OP, h_head, h_sq};
                proc.cmd_rdy = 1'b1;
                if (proc.clr_cmd_rdy) state_nxt = WAIT_H;
            end
            WAIT_H: begin
                proc.cmd = {HORZ_OP, h_head, h_sq};
                if (indx == LAST_INDX) proc.resp = RESP_ACK;
                if (proc.send_resp) begin
                    if (indx == LAST_INDX) begin
                        done_nxt  = 1'b1;
                        state_nxt = IDLE;
                    end else begin
                        indx_nxt  = indx + 5'd1;
                        state_nxt = VERT;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_tour_cmd_seq.sv
// Scoreboard bench for tour_cmd_seq: a move-table reference model queues expected legs,
// a negedge monitor pops and compares each command the sequencer presents.
module tb_tour_cmd_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start_tour;
    logic [7:0]  move;
    logic [4:0]  indx;
    logic [15:0] cmd_UART;
    logic        cmd_rdy_UART;
    logic        clr_cmd_rdy_UART;
    logic        tour_done;

    tour_cmd_seq_if bus ();

    tour_cmd_seq dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .start_tour       (start_tour),
        .move             (move),
        .indx             (indx),
        .cmd_UART         (cmd_UART),
        .cmd_rdy_UART     (cmd_rdy_UART),
        .clr_cmd_rdy_UART (clr_cmd_rdy_UART),
        .tour_done        (tour_done),
        .proc             (bus)
    );

    always #5 clk = ~clk;

    logic [7:0] moves [32];
    assign move = moves[indx];

    typedef struct {
        logic [15:0] cmd;
        logic [4:0]  indx;
        logic [7:0]  resp_wait;
        bit          last;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   fails = 0;
    int   done_pulses = 0;
    bit   tour_active = 0;

    int DX [8] = '{-1,  1, -2, -2, -1,  1,  2,  2};
    int DY [8] = '{ 2,  2,  1, -1, -2, -2, -1,  1};

`ifdef TOUR_FANFARE_EN
    int HORZ_OPC = 5;
`else
    int HORZ_OPC = 4;
`endif

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void ref_legs(input logic [7:0] m, output logic [15:0] vcmd, output logic [15:0] hcmd);
        int b = 0;
        int dx, dy, v, h;
        for (int i = 7; i >= 0; i--) if (m[i]) b = i;
        dx = DX[b];
        dy = DY[b];
        v = (4 << 12) | ((dy > 0 ? 'h00 : 'h7F) << 4) | (dy > 0 ? dy : -dy);
        h = (HORZ_OPC << 12) | ((dx > 0 ? 'hBF : 'h3F) << 4) | (dx > 0 ? dx : -dx);
        vcmd = v[15:0];
        hcmd = h[15:0];
    endfunction

    // Scoreboard monitor
    initial begin
        bit   prev_rdy = 0;
        bit   have_cur = 0;
        bit   exp_done_now = 0;
        bit   next_done;
        exp_t cur;
        forever begin
            @(negedge clk);
            check("tour_done", tour_done, exp_done_now);
            next_done = 0;
            if (tour_active && rst_n) begin
                if (bus.cmd_rdy && !prev_rdy) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_cmd", bus.cmd, 32'hFFFF_FFFF);
                    end else begin
                        cur = exp_q.pop_front();
                        have_cur = 1;
                        check("leg_cmd", bus.cmd, cur.cmd);
                        check("leg_indx", indx, cur.indx);
                        check("leg_resp", bus.resp, 8'h5A);
                    end
                end
                if (bus.send_resp && !bus.clr_cmd_rdy && !bus.cmd_rdy && have_cur) begin
                    check("wait_resp", bus.resp, cur.resp_wait);
                    next_done = cur.last;
                end
            end
            if (tour_done) done_pulses++;
            exp_done_now = next_done;
            prev_rdy = bus.cmd_rdy;
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic begin_tour;
        logic [15:0] vc, hc;
        for (int k = 0; k < 24; k++) begin
            ref_legs(moves[k], vc, hc);
            exp_q.push_back('{vc, 5'(k), 8'h5A, 1'b0});
            exp_q.push_back('{hc, 5'(k), (k == 23) ? 8'hA5 : 8'h5A, k == 23});
        end
        start_tour = 1'b1;
        tour_active = 1;
        tick();
        start_tour = 1'b0;
        check("start_latency", bus.cmd_rdy, 1'b1);
    endtask

    // Processor model; abort_leg stops in the wait state after that leg's clr.
    task automatic run_legs(input int n, input int abort_leg, input int ignore_leg);
        int   cnt;
        logic [4:0] saved;
        for (int leg = 0; leg < n; leg++) begin
            cnt = 0;
            while (!bus.cmd_rdy && cnt < 50) begin tick(); cnt++; end
            if (!bus.cmd_rdy) begin
                check("leg_timeout", 32'd0, 32'd1);
                return;
            end
            repeat ($urandom_range(0, 3)) tick();
            bus.clr_cmd_rdy = 1'b1;
            bus.send_resp = ($urandom_range(0, 3) == 0);
            tick();
            bus.clr_cmd_rdy = 1'b0;
            bus.send_resp = 1'b0;
            if (leg == abort_leg) return;
            if (leg == ignore_leg) begin
                saved = indx;
                start_tour = 1'b1;
                cmd_rdy_UART = 1'b1;
                bus.clr_cmd_rdy = 1'b1;
                #1;
                check("busy_clr_uart", clr_cmd_rdy_UART, 1'b0);
                check("busy_cmd_rdy", bus.cmd_rdy, 1'b0);
                tick();
                start_tour = 1'b0;
                cmd_rdy_UART = 1'b0;
                bus.clr_cmd_rdy = 1'b0;
                check("busy_indx", indx, saved);
                check("busy_cmd_rdy_after", bus.cmd_rdy, 1'b0);
            end
            repeat ($urandom_range(0, 3)) tick();
            bus.send_resp = 1'b1;
            tick();
            bus.send_resp = 1'b0;
        end
    endtask

    task automatic random_moves;
        for (int k = 0; k < 32; k++) begin
            if ($urandom_range(0, 3) == 0) moves[k] = 8'($urandom);
            else moves[k] = 8'(1 << $urandom_range(0, 7));
        end
    endtask

    initial begin
        logic [15:0] pats [4];
        pats[0] = 16'h2000; pats[1] = 16'hFFFF; pats[2] = 16'h0000; pats[3] = 16'h8A51;

        rst_n = 1'b0;
        start_tour = 1'b0;
        cmd_UART = 16'h1234;
        cmd_rdy_UART = 1'b0;
        bus.clr_cmd_rdy = 1'b0;
        bus.send_resp = 1'b0;
        random_moves();
        repeat (2) tick();
        check("rst_indx", indx, 5'd0);
        check("rst_done", tour_done, 1'b0);
        check("rst_cmd", bus.cmd, 16'h1234);
        check("rst_cmd_rdy", bus.cmd_rdy, 1'b0);
        check("rst_resp", bus.resp, 8'hA5);
        rst_n = 1'b1;
        tick();

        for (int p = 0; p < 4; p++) begin
            cmd_UART = pats[p];
            cmd_rdy_UART = p[0] ? 1'b0 : 1'b1;
            bus.clr_cmd_rdy = (p != 2);
            #1;
            check("idle_cmd", bus.cmd, pats[p]);
            check("idle_cmd_rdy", bus.cmd_rdy, cmd_rdy_UART);
            check("idle_clr_uart", clr_cmd_rdy_UART, bus.clr_cmd_rdy);
            check("idle_resp", bus.resp, 8'hA5);
            tick();
        end
        cmd_rdy_UART = 1'b0;
        bus.clr_cmd_rdy = 1'b0;
        tick();

        moves[0] = 8'h80;
        moves[1] = 8'h10;
        moves[2] = 8'h00;
        moves[3] = 8'h06;
        moves[4] = 8'hC8;
        begin_tour();
        run_legs(48, -1, 10);
        repeat (3) tick();
        tour_active = 0;
        cmd_rdy_UART = 1'b1;
        #1;
        check("back_to_idle", bus.cmd_rdy, 1'b1);
        cmd_rdy_UART = 1'b0;
        tick();

        random_moves();
        begin_tour();
        run_legs(16, 15, -1);
        check("abort_indx", indx, 5'd7);
        cmd_UART = 16'hBEEF;
        rst_n = 1'b0;
        tour_active = 0;
        #1;
        check("abort_rst_indx", indx, 5'd0);
        check("abort_rst_done", tour_done, 1'b0);
        check("abort_rst_cmd", bus.cmd, 16'hBEEF);
        check("abort_rst_rdy", bus.cmd_rdy, 1'b0);
        check("abort_rst_resp", bus.resp, 8'hA5);
        exp_q.delete();
        repeat (2) tick();
        rst_n = 1'b1;
        tick();

        random_moves();
        begin_tour();
        run_legs(48, -1, -1);
        repeat (3) tick();
        tour_active = 0;
        check("queue_drained", exp_q.size(), 0);
        check("done_pulses", done_pulses, 2);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/tour_cmd_seq.md
# tour_cmd_seq

Sequencer that plays back a solved knight's tour. After `start_tour`, it reads the 24 one-hot moves from the tour solver by index and splits each L-shaped move into two straight-line commands: a vertical leg, then a horizontal leg. It presents each command to the downstream command processor with a ready/clear/response handshake. When idle, it passes host (UART) commands straight through, so it sits as the command mux between the UART wrapper and the command processor.

## Interface
- No parameters.
- clk  in  1  system clock.
- rst_n  in  1  reset, asynchronous, active-low.
- start_tour  in  1  single-cycle request to play back the solved tour; honoured only in IDLE.
- move  in  8  one-hot move from the solver at address `indx`.
- indx  out  5  index of the move being executed, 0..23.
- cmd_UART  in  16  host command.
- cmd_rdy_UART  in  1  host command valid.
- clr_cmd_rdy_UART  out  1  consume strobe forwarded to the UART side.
- cmd  out  16  command to the processor: [15:12] opcode, [11:4] heading, [3:0] squares.
- cmd_rdy  out  1  `cmd` valid.
- clr_cmd_rdy  in  1  processor has consumed `cmd`.
- send_resp  in  1  processor has finished executing the current command.
- resp  out  8  response byte: 8'h5A = tour leg acknowledged, 8'hA5 = final/normal acknowledge.
- tour_done  out  1  single-cycle pulse when the last leg of move 23 completes.

## Operation
- Move decode, as (dx, dy):
  - bit0 (-1,+2), bit1 (+1,+2), bit2 (-2,+1), bit3 (-2,-1)
  - bit4 (-1,-2), bit5 (+1,-2), bit6 (+2,-1), bit7 (+2,+1)
  - Non-one-hot input: the lowest set bit wins. 8'h00 decodes as bit0.
- Vertical leg: heading north 8'h00 if dy>0, south 8'h7F if dy<0; squares = |dy|.
- Horizontal leg: heading east 8'hBF if dx>0, west 8'h3F if dx<0; squares = |dx|.
- Opcode: 4'b0100 (move) for the vertical leg; the horizontal-leg opcode is set per Configuration.
- States: IDLE, VERT, WAIT_V, HORZ, WAIT_H.
  - IDLE: `cmd`=`cmd_UART`, `cmd_rdy`=`cmd_rdy_UART`, `clr_cmd_rdy_UART`=`clr_cmd_rdy`. On `start_tour`: `indx`<=0, go to VERT.
  - VERT: `cmd`=vertical leg, `cmd_rdy`=1. On `clr_cmd_rdy`, go to WAIT_V.
  - WAIT_V: `cmd_rdy`=0. On `send_resp`, go to HORZ.
  - HORZ: `cmd`=horizontal leg, `cmd_rdy`=1. On `clr_cmd_rdy`, go to WAIT_H.
  - WAIT_H: `cmd_rdy`=0. On `send_resp`:
    - if `indx`==23: pulse `tour_done` and go to IDLE;
    - else: `indx`<=`indx`+1 and go to VERT.
- Outside IDLE, `cmd_rdy_UART` is ignored, `clr_cmd_rdy_UART` is held 0, and `start_tour` is ignored.
- `resp` = 8'hA5 in IDLE, and also in WAIT_H when `indx`==23; otherwise 8'h5A.
- `indx` is a 5-bit register that is only ever loaded with 0..23; it never wraps.

## Timing
- Reset values: state IDLE, `indx` 0, `tour_done` 0. `cmd`, `cmd_rdy`, `clr_cmd_rdy_UART` and `resp` follow the IDLE passthrough / 8'hA5.
- `cmd`, `cmd_rdy`, `resp` and `clr_cmd_rdy_UART` are combinational from the registered state, `indx`, `move` and the UART inputs. `move` must be stable one cycle after `indx` changes, which the solver's array read guarantees.
- `start_tour` to `cmd_rdy`=1 with the vertical leg: 1 cycle.
- `clr_cmd_rdy` drops `cmd_rdy` on the next cycle.
- If `clr_cmd_rdy` and `send_resp` arrive in the same cycle in VERT or HORZ, only `clr_cmd_rdy` is acted on.
- `send_resp` in VERT, HORZ or IDLE is ignored.
- `tour_done` is registered: it is high for exactly the one cycle after the final `send_resp`.
- Reset asserted mid-tour returns the block to IDLE with `indx`=0 immediately. No partial command is held.

## Configuration
- `TOUR_FANFARE_EN` defined: the horizontal leg uses opcode 4'b0101 (move with fanfare).
- `TOUR_FANFARE_EN` undefined: both legs use 4'b0100.
- No other behaviour differs between the two builds.

## Test plan
- Reset, then drive `cmd_UART`=16'h2000 with `cmd_rdy_UART`=1 in IDLE -> `cmd`=16'h2000, `cmd_rdy`=1, `resp`=8'hA5. A `clr_cmd_rdy` pulse appears on `clr_cmd_rdy_UART` in the same cycle.
- `start_tour` with `move`[0]=8'h80 -> `cmd`=16'h4001 (north 1). After clr/send_resp, `cmd`=16'h4BF2, or 16'h5BF2 with `TOUR_FANFARE_EN`. `resp`=8'h5A.
- `move`=8'h10 -> `cmd` 16'h47F2 (south 2), then 16'h43F1 (west 1), or 16'h53F1 with `TOUR_FANFARE_EN`.
- Full 24-move tour with randomised handshake delays -> 48 commands issued, `indx` steps 0..23, `resp`=8'hA5 on the final leg, `tour_done` pulses once, state returns to IDLE.
- `start_tour` and `cmd_rdy_UART` asserted mid-tour -> ignored: `indx` unchanged and `clr_cmd_rdy_UART` stays 0.
- `rst_n` asserted in WAIT_H at `indx`=7 -> IDLE, `indx`=0, `tour_done`=0. A subsequent `start_tour` restarts the tour from `indx` 0.
